// File: rtl/conv2d_stream_if.sv
// conv2d_stream_if
//   Stream bundle for conv2d_stream_engine: the input beat stream carrying
//   coefficients or image samples (row-major) and the result stream.
//   Parameters:
//     DW : signed input sample/coefficient width
//     OW : signed result width
//   Signals:
//     in_valid / in_ready / in_data    : input stream handshake and payload
//     out_valid / out_ready / out_data : result stream handshake and payload
//   Modports:
//     master : the side feeding samples and consuming results (DMA / bench)
//     slave  : the engine side
interface conv2d_stream_if #(
    parameter int DW = 8,
    parameter int OW = 16
) ();

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

endinterface

// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine
//   Valid-mode 2D correlation (no kernel flip) of an N x N signed image with
//   a K x K signed kernel at a selectable stride S (0 behaves as 1). Kernel
//   and image are streamed into internal single-port synchronous RAMs, the
//   results are computed one MAC per cycle into a result RAM and then
//   streamed out row-major. Output dimension M = floor((N-K)/S)+1.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     cfg_n/cfg_k       : image / kernel dimension, latched on command accept
//     cfg_stride        : stride, latched on command accept
//     load_h/load_x     : command pulses to stream in K*K coefficients / N*N samples
//     start             : command pulse to compute and stream all results
//     strm (slave)      : input stream (in_*) and result stream (out_*)
//     busy              : engine is not idle
//     done              : one-cycle pulse after the last result handshake
//     err               : one-cycle pulse when a command is rejected
//   Optional build macro:
//     CONV2D_SAT_EN     : saturate results to the OW-bit signed range instead
//                         of keeping the low OW bits (two's-complement wrap)
module conv2d_stream_engine #(
    parameter int DW    = 8,
    parameter int OW    = 16,
    parameter int MAX_N = 32,
    parameter int MAX_K = 8,
    parameter int ACCW  = 2*DW + 2*$clog2(MAX_K),
    parameter int NW    = $clog2(MAX_N+1),
    parameter int KW    = $clog2(MAX_K+1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NW-1:0]          cfg_n,
    input  logic [KW-1:0]          cfg_k,
    input  logic [1:0]             cfg_stride,
    input  logic                   load_h,
    input  logic                   load_x,
    input  logic                   start,
    conv2d_stream_if.slave         strm,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int XDEPTH = MAX_N*MAX_N;
    localparam int HDEPTH = MAX_K*MAX_K;
    localparam int XAW    = $clog2(XDEPTH);
    localparam int HAW    = $clog2(HDEPTH);
    localparam int CW     = $clog2(XDEPTH+1);

`ifdef CONV2D_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (OW-1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(64'sd1 <<< (OW-1)));
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_H,
        S_LOAD_X,
        S_MAC,
        S_WRITE,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [NW-1:0]          n_q, n_d;
    logic [KW-1:0]          k_q, k_d;
    logic [1:0]             s_q, s_d;
    logic [CW-1:0]          kk_q, kk_d;
    logic [CW-1:0]          nn_q, nn_d;
    logic [NW-1:0]          m_q, m_d;
    logic [CW-1:0]          mm_q, mm_d;
    logic [CW-1:0]          idx_q, idx_d;
    logic [KW-1:0]          i_q, i_d;
    logic [KW-1:0]          j_q, j_d;
    logic [NW-1:0]          r_q, r_d;
    logic [NW-1:0]          c_q, c_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [CW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   rv_q, rv_d;
    logic                   out_valid_q, out_valid_d;
    logic [OW-1:0]          out_data_q, out_data_d;
    logic [CW-1:0]          out_cnt_q, out_cnt_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    // Single-port synchronous RAMs and their registered read data.
    logic signed [DW-1:0] x_mem [XDEPTH];
    logic signed [DW-1:0] h_mem [HDEPTH];
    logic        [OW-1:0] y_mem [XDEPTH];
    logic signed [DW-1:0] x_rdata_q;
    logic signed [DW-1:0] h_rdata_q;
    logic        [OW-1:0] y_rdata_q;

    logic           x_we, x_re, h_we, h_re, y_we, y_re;
    logic [XAW-1:0] x_addr;
    logic [HAW-1:0] h_addr;
    logic [XAW-1:0] y_addr;
    logic [OW-1:0]  y_wdata;

    logic                   in_ready_w;
    logic                   in_beat;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] prod_ext;

    logic       cmd_any;
    logic       cmd_bad;
    logic [1:0] cmd_stride;
    int         cmd_diff;
    int         cmd_m;

    logic c_accept, b_move, b_accept, rd_issue, out_fire;

    // Reduce the wide accumulator to the result width. The accumulator is
    // sized so that the full sum never overflows; only this step loses range.
    function automatic logic [OW-1:0] reduce_acc(input logic signed [ACCW-1:0] a);
`ifdef CONV2D_SAT_EN
        if (a > SAT_MAX) begin
            return SAT_MAX[OW-1:0];
        end else if (a < SAT_MIN) begin
            return SAT_MIN[OW-1:0];
        end else begin
            return a[OW-1:0];
        end
`else
        return a[OW-1:0];
`endif
    endfunction

    assign in_ready_w    = (state_q == S_LOAD_H) || (state_q == S_LOAD_X);
    assign in_beat       = strm.in_valid && in_ready_w;
    assign strm.in_ready = in_ready_w;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;

    assign prod     = x_rdata_q * h_rdata_q;
    assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

    // Command validation and derived geometry from the live cfg inputs; these
    // only take effect when a command is accepted in IDLE. The stride is at
    // most 3, so M is a divide by a small constant.
    always_comb begin
        cmd_any    = start || load_h || load_x;
        cmd_stride = (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
        cmd_bad    = (cfg_k == '0) || (int'(cfg_k) > MAX_K) ||
                     (int'(cfg_n) > MAX_N) || (int'(cfg_k) > int'(cfg_n));
        cmd_diff   = int'(cfg_n) - int'(cfg_k);
        case (cmd_stride)
            2'd2:    cmd_m = cmd_diff / 2 + 1;
            2'd3:    cmd_m = cmd_diff / 3 + 1;
            default: cmd_m = cmd_diff + 1;
        endcase
    end

    // Main next-state logic. MAC issues one X/H read per cycle for K*K
    // cycles; products are accumulated one cycle later, so the state lasts
    // K*K+1 cycles and WRITE follows. DRAIN runs a three-stage read pipeline
    // (address issue, RAM data, output register) that only advances when the
    // stage in front of it can take data, giving stable output under stall
    // and full throughput when out_ready stays high.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        s_d         = s_q;
        kk_d        = kk_q;
        nn_d        = nn_q;
        m_d         = m_q;
        mm_d        = mm_q;
        idx_d       = idx_q;
        i_d         = i_q;
        j_d         = j_q;
        r_d         = r_q;
        c_d         = c_q;
        acc_d       = acc_q;
        rd_ptr_d    = rd_ptr_q;
        rv_d        = rv_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        x_we        = 1'b0;
        x_re        = 1'b0;
        x_addr      = '0;
        h_we        = 1'b0;
        h_re        = 1'b0;
        h_addr      = '0;
        y_we        = 1'b0;
        y_re        = 1'b0;
        y_addr      = '0;
        y_wdata     = '0;
        c_accept    = 1'b0;
        b_move      = 1'b0;
        b_accept    = 1'b0;
        rd_issue    = 1'b0;
        out_fire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_any) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        n_d   = cfg_n;
                        k_d   = cfg_k;
                        s_d   = cmd_stride;
                        kk_d  = CW'(int'(cfg_k) * int'(cfg_k));
                        nn_d  = CW'(int'(cfg_n) * int'(cfg_n));
                        m_d   = NW'(cmd_m);
                        mm_d  = CW'(cmd_m * cmd_m);
                        idx_d = '0;
                        i_d   = '0;
                        j_d   = '0;
                        r_d   = '0;
                        c_d   = '0;
                        if (start) begin
                            state_d = S_MAC;
                        end else if (load_h) begin
                            state_d = S_LOAD_H;
                        end else begin
                            state_d = S_LOAD_X;
                        end
                    end
                end
            end

            S_LOAD_H: begin
                if (in_beat) begin
                    h_we   = 1'b1;
                    h_addr = HAW'(idx_q);
                    idx_d  = idx_q + CW'(1);
                    if (idx_q == kk_q - CW'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_LOAD_X: begin
                if (in_beat) begin
                    x_we   = 1'b1;
                    x_addr = XAW'(idx_q);
                    idx_d  = idx_q + CW'(1);
                    if (idx_q == nn_q - CW'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_MAC: begin
                if (idx_q < kk_q) begin
                    x_re   = 1'b1;
                    h_re   = 1'b1;
                    x_addr = XAW'((int'(r_q) * int'(s_q) + int'(i_q)) * int'(n_q) +
                                  int'(c_q) * int'(s_q) + int'(j_q));
                    h_addr = HAW'(idx_q);
                    if (j_q == k_q - KW'(1)) begin
                        j_d = '0;
                        i_d = i_q + KW'(1);
                    end else begin
                        j_d = j_q + KW'(1);
                    end
                end
                if (idx_q != '0) begin
                    acc_d = (idx_q == CW'(1)) ? prod_ext : acc_q + prod_ext;
                end
                idx_d = idx_q + CW'(1);
                if (idx_q == kk_q) begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                y_we    = 1'b1;
                y_addr  = XAW'(int'(r_q) * int'(m_q) + int'(c_q));
                y_wdata = reduce_acc(acc_q);
                idx_d   = '0;
                i_d     = '0;
                j_d     = '0;
                state_d = S_MAC;
                if (c_q == m_q - NW'(1)) begin
                    c_d = '0;
                    if (r_q == m_q - NW'(1)) begin
                        state_d     = S_DRAIN;
                        rd_ptr_d    = '0;
                        rv_d        = 1'b0;
                        out_valid_d = 1'b0;
                        out_cnt_d   = '0;
                    end else begin
                        r_d = r_q + NW'(1);
                    end
                end else begin
                    c_d = c_q + NW'(1);
                end
            end

            S_DRAIN: begin
                out_fire = out_valid_q && strm.out_ready;
                c_accept = !out_valid_q || strm.out_ready;
                b_move   = rv_q && c_accept;
                b_accept = !rv_q || b_move;
                rd_issue = (rd_ptr_q < mm_q) && b_accept;
                if (c_accept) begin
                    out_valid_d = rv_q;
                    if (rv_q) begin
                        out_data_d = y_rdata_q;
                    end
                end
                if (b_accept) begin
                    rv_d = rd_issue;
                end
                if (rd_issue) begin
                    y_re     = 1'b1;
                    y_addr   = XAW'(rd_ptr_q);
                    rd_ptr_d = rd_ptr_q + CW'(1);
                end
                if (out_fire) begin
                    out_cnt_d = out_cnt_q + CW'(1);
                    if (out_cnt_q == mm_q - CW'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers. Reset aborts whatever is running and
    // returns to IDLE without a done pulse; RAM contents are left intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            s_q         <= '0;
            kk_q        <= '0;
            nn_q        <= '0;
            m_q         <= '0;
            mm_q        <= '0;
            idx_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            rd_ptr_q    <= '0;
            rv_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            s_q         <= s_d;
            kk_q        <= kk_d;
            nn_q        <= nn_d;
            m_q         <= m_d;
            mm_q        <= mm_d;
            idx_q       <= idx_d;
            i_q         <= i_d;
            j_q         <= j_d;
            r_q         <= r_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            rd_ptr_q    <= rd_ptr_d;
            rv_q        <= rv_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // RAM bodies: one access per cycle each, read data registered and held
    // while no read is issued (the drain pipeline relies on that hold).
    always_ff @(posedge clk) begin
        if (x_we) begin
            x_mem[x_addr] <= strm.in_data;
        end
        if (x_re) begin
            x_rdata_q <= x_mem[x_addr];
        end
        if (h_we) begin
            h_mem[h_addr] <= strm.in_data;
        end
        if (h_re) begin
            h_rdata_q <= h_mem[h_addr];
        end
        if (y_we) begin
            y_mem[y_addr] <= y_wdata;
        end
        if (y_re) begin
            y_rdata_q <= y_mem[y_addr];
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine
//   Directed bench for conv2d_stream_engine: hand-computed result vectors
//   for the basic correlation, stride handling, output backpressure, input
//   gaps, mid-run reset, command rejection and result width reduction.
module tb_conv2d_stream_engine;

    logic       clk;
    logic       reset;
    logic [5:0] cfg_n;
    logic [3:0] cfg_k;
    logic [1:0] cfg_stride;
    logic       load_h;
    logic       load_x;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;

    conv2d_stream_if #(.DW(8), .OW(16)) strm ();

    conv2d_stream_engine dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_n      (cfg_n),
        .cfg_k      (cfg_k),
        .cfg_stride (cfg_stride),
        .load_h     (load_h),
        .load_x     (load_x),
        .start      (start),
        .strm       (strm),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int vals[$];
    int got[$];
    int first_valid;
    int stall_viol;
    int done_early;
    logic done_next, busy_next, done_after, valid_after;
    bit timed_out;
    bit load_timeout;

    // Pulse one command with the given configuration, then scramble cfg so
    // that only the latched copy can be in use afterwards.
    task automatic send_cmd(input int which, input int n, input int k, input int s);
        cfg_n      = 6'(n);
        cfg_k      = 4'(k);
        cfg_stride = 2'(s);
        start  = (which == 0);
        load_h = (which == 1);
        load_x = (which == 2);
        @(posedge clk); #1;
        start  = 1'b0;
        load_h = 1'b0;
        load_x = 1'b0;
        cfg_n      = 6'd0;
        cfg_k      = 4'd0;
        cfg_stride = 2'd3;
    endtask

    // Stream vals[] into the engine after a load command; gaps drop in_valid
    // every third cycle.
    task automatic load_stream(input int which, input int n, input int k, input bit gaps);
        int beats = 0;
        int cyc = 0;
        bit acc;
        bit gap;
        send_cmd(which, n, k, 1);
        while (beats < vals.size() && cyc < 5000) begin
            gap = gaps && ((cyc % 3) == 1);
            strm.in_valid = !gap;
            strm.in_data  = 8'(vals[beats]);
            acc = !gap && strm.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) beats++;
        end
        strm.in_valid = 1'b0;
        load_timeout = (beats < vals.size());
    endtask

    // Collect n_exp results, optionally withholding out_ready for stall_len
    // valid cycles once stall_at results have been taken.
    task automatic collect(input int n_exp, input int stall_at, input int stall_len);
        int cyc = 0;
        int hs = 0;
        int stalled = 0;
        bit prev_stall = 0;
        logic [15:0] prev_data = '0;
        bit rdy;
        got.delete();
        first_valid = -1;
        stall_viol = 0;
        done_early = 0;
        while (hs < n_exp && cyc < 5000) begin
            if (strm.out_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (strm.out_valid !== 1'b1 || strm.out_data !== prev_data)) stall_viol++;
            if (done === 1'b1) done_early++;
            rdy = 1'b1;
            if (hs == stall_at && stalled < stall_len && strm.out_valid) begin
                rdy = 1'b0;
                stalled++;
            end
            strm.out_ready = rdy;
            if (strm.out_valid && rdy) begin
                got.push_back(int'($signed(strm.out_data)));
                hs++;
            end
            prev_stall = strm.out_valid && !rdy;
            prev_data  = strm.out_data;
            @(posedge clk); #1;
            cyc++;
        end
        strm.out_ready = 1'b1;
        timed_out = (hs < n_exp);
        done_next = done;
        busy_next = busy;
        @(posedge clk); #1;
        done_after  = done;
        valid_after = strm.out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, err, strm.in_ready, strm.out_valid} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000", {busy, done, err, strm.in_ready, strm.out_valid});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({busy, done, err, strm.in_ready, strm.out_valid} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL idle_outputs: got %b expected 00000", {busy, done, err, strm.in_ready, strm.out_valid});
        end
    endtask

    task automatic test_basic();
        vals = '{1, 0, 0, -1};
        load_stream(1, 4, 2, 0);
        vals.delete();
        for (int i = 0; i < 16; i++) vals.push_back(i);
        load_stream(2, 4, 2, 0);
        tests++;
        if (load_timeout !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_load: timeout %0b busy %0b expected 0 0", load_timeout, busy);
        end
        send_cmd(0, 4, 2, 1);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_busy: got %b expected 1", busy);
        end
        collect(9, -1, 0);
        tests++;
        if (timed_out !== 1'b0 || got.size() != 9) begin
            fails++;
            $display("[TB] FAIL basic_count: got %0d results expected 9", got.size());
        end
        for (int i = 0; i < 9; i++) begin
            int g = (i < got.size()) ? got[i] : -99999;
            tests++;
            if (g !== -5) begin
                fails++;
                $display("[TB] FAIL basic_out%0d: got %0d expected -5", i, g);
            end
        end
        tests++;
        if (first_valid !== 56) begin
            fails++;
            $display("[TB] FAIL basic_latency: got %0d expected 56", first_valid);
        end
        tests++;
        if (done_next !== 1'b1 || busy_next !== 1'b0 || done_early !== 0) begin
            fails++;
            $display("[TB] FAIL basic_done: done %b busy %b early %0d expected 1 0 0", done_next, busy_next, done_early);
        end
        tests++;
        if (done_after !== 1'b0 || valid_after !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_after: done %b valid %b expected 0 0", done_after, valid_after);
        end
    endtask

    task automatic test_backpressure();
        int expv[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        vals = '{1, 0, 0, 0};
        load_stream(1, 4, 2, 0);
        send_cmd(0, 4, 2, 1);
        collect(9, 4, 3);
        tests++;
        if (timed_out !== 1'b0 || got.size() != 9 || stall_viol !== 0) begin
            fails++;
            $display("[TB] FAIL bp_stream: got %0d results, %0d unstable stall cycles expected 9 and 0", got.size(), stall_viol);
        end
        for (int i = 0; i < 9; i++) begin
            int g = (i < got.size()) ? got[i] : -99999;
            tests++;
            if (g !== expv[i]) begin
                fails++;
                $display("[TB] FAIL bp_out%0d: got %0d expected %0d", i, g, expv[i]);
            end
        end
        tests++;
        if (done_next !== 1'b1 || done_early !== 0) begin
            fails++;
            $display("[TB] FAIL bp_done: got %b (early %0d) expected 1 (0)", done_next, done_early);
        end
    endtask

    task automatic test_load_gaps();
        int expv[9] = '{15, 14, 13, 11, 10, 9, 7, 6, 5};
        vals.delete();
        for (int i = 0; i < 16; i++) vals.push_back(15 - i);
        load_stream(2, 4, 2, 1);
        tests++;
        if (load_timeout !== 1'b0) begin
            fails++;
            $display("[TB] FAIL gaps_load: timeout got %b expected 0", load_timeout);
        end
        send_cmd(0, 4, 2, 1);
        collect(9, -1, 0);
        for (int i = 0; i < 9; i++) begin
            int g = (i < got.size()) ? got[i] : -99999;
            tests++;
            if (g !== expv[i]) begin
                fails++;
                $display("[TB] FAIL gaps_out%0d: got %0d expected %0d", i, g, expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int expv[9] = '{15, 14, 13, 11, 10, 9, 7, 6, 5};
        int seen_done = 0;
        send_cmd(0, 4, 2, 1);
        repeat (20) begin
            if (done === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        tests++;
        if (busy !== 1'b1 || seen_done !== 0) begin
            fails++;
            $display("[TB] FAIL midreset_pre: busy %b done seen %0d expected 1 0", busy, seen_done);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++;
        if (busy !== 1'b0 || strm.out_valid !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_abort: busy %b valid %b done %b expected 0 0 0", busy, strm.out_valid, done);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_nodone: done %b busy %b expected 0 0", done, busy);
        end
        send_cmd(0, 4, 2, 1);
        collect(9, -1, 0);
        for (int i = 0; i < 9; i++) begin
            int g = (i < got.size()) ? got[i] : -99999;
            tests++;
            if (g !== expv[i]) begin
                fails++;
                $display("[TB] FAIL midreset_out%0d: got %0d expected %0d", i, g, expv[i]);
            end
        end
    endtask

    task automatic test_reject();
        int bad = 0;
        send_cmd(0, 4, 5, 1);
        tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reject_err: err %b busy %b expected 1 0", err, busy);
        end
        repeat (6) begin
            @(posedge clk); #1;
            if (err !== 1'b0 || busy !== 1'b0 || strm.out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("[TB] FAIL reject_after: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_stride();
        vals.delete();
        for (int i = 0; i < 9; i++) vals.push_back(1);
        load_stream(1, 5, 3, 0);
        vals.delete();
        for (int i = 0; i < 25; i++) vals.push_back(1);
        load_stream(2, 5, 3, 0);
        send_cmd(0, 5, 3, 2);
        collect(4, -1, 0);
        tests++;
        if (timed_out !== 1'b0 || got.size() != 4 || first_valid !== 46) begin
            fails++;
            $display("[TB] FAIL stride2_count: got %0d results, first valid %0d expected 4 and 46", got.size(), first_valid);
        end
        for (int i = 0; i < 4; i++) begin
            int g = (i < got.size()) ? got[i] : -99999;
            tests++;
            if (g !== 9) begin
                fails++;
                $display("[TB] FAIL stride2_out%0d: got %0d expected 9", i, g);
            end
        end
        tests++;
        if (done_next !== 1'b1 || valid_after !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stride2_done: done %b valid %b expected 1 0", done_next, valid_after);
        end
        send_cmd(0, 5, 3, 0);
        collect(9, -1, 0);
        tests++;
        if (timed_out !== 1'b0 || got.size() != 9 || done_next !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stride0_count: got %0d results done %b expected 9 1", got.size(), done_next);
        end
        for (int i = 0; i < 9; i++) begin
            int g = (i < got.size()) ? got[i] : -99999;
            tests++;
            if (g !== 9) begin
                fails++;
                $display("[TB] FAIL stride0_out%0d: got %0d expected 9", i, g);
            end
        end
    endtask

    task automatic test_width();
        int expv;
`ifdef CONV2D_SAT_EN
        expv = 32767;
`else
        expv = 0;
`endif
        vals.delete();
        for (int i = 0; i < 64; i++) vals.push_back(-128);
        load_stream(1, 8, 8, 0);
        load_stream(2, 8, 8, 0);
        send_cmd(0, 8, 8, 1);
        collect(1, -1, 0);
        tests++;
        if (timed_out !== 1'b0 || got.size() != 1 || first_valid !== 68) begin
            fails++;
            $display("[TB] FAIL width_count: got %0d results, first valid %0d expected 1 and 68", got.size(), first_valid);
        end
        tests++;
        if (got.size() < 1 || got[0] !== expv) begin
            fails++;
            $display("[TB] FAIL width_out: got %0d expected %0d", (got.size() > 0) ? got[0] : -99999, expv);
        end
        tests++;
        if (done_next !== 1'b1 || done_after !== 1'b0) begin
            fails++;
            $display("[TB] FAIL width_done: done %b then %b expected 1 then 0", done_next, done_after);
        end
    endtask

    initial begin
        reset          = 1'b1;
        cfg_n          = '0;
        cfg_k          = '0;
        cfg_stride     = '0;
        load_h         = 1'b0;
        load_x         = 1'b0;
        start          = 1'b0;
        strm.in_valid  = 1'b0;
        strm.in_data   = '0;
        strm.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_load_gaps();
        test_reset_mid();
        test_reject();
        test_stride();
        test_width();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
